// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage feeding the opcode decoder / control unit.
// Holds the program counter, issues reads to a synchronous instruction memory
// (one-cycle read latency) and buffers returned words in an output register
// backed by a one-entry skid buffer. Words are handed to decode in program
// order over a valid/ready handshake. Taken branches from execute redirect the
// PC and flush everything fetched down the old path.
//
// Optional feature (compile-time macro FETCH_HALT_EN):
//   When defined, accepting an instruction whose opcode (top 4 bits) is 4'hF
//   stops fetch in the HALT state and sets the sticky 'halted' flag until
//   reset. When undefined, opcode 4'hF is an ordinary word and 'halted' is 0.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous, active-high reset
//   imem_en        read request this cycle
//   imem_addr      read address (the registered PC)
//   imem_rdata     read data, valid the cycle after imem_en
//   instr_valid    instr / instr_pc hold a valid instruction
//   instr_ready    decode accepts this cycle
//   instr          instruction word to decode (opcode = top 4 bits)
//   instr_pc       address of instr
//   branch_taken   single-cycle redirect request from execute
//   branch_pc      address of the taken branch
//   branch_offset  signed offset of the taken branch
//   halted         sticky halt indicator
//
// Handshake: a word transfers to decode in every cycle where instr_valid and
// instr_ready are both high. While instr_valid is high and instr_ready is low,
// instr and instr_pc are held unchanged; instr_valid never drops without a
// transfer except on a branch redirect, a halt, or reset.
//
// The FSM state is held in state_q (type state_e) for observation.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int OFF_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_pc,
  input  logic [OFF_W-1:0]   branch_offset,
  output logic               halted
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Program counter: address of the next read to issue.
  logic [PC_W-1:0] pc_q, pc_d;

  // A read was issued last cycle; its data is on imem_rdata this cycle.
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

  // Output register (what decode sees).
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [PC_W-1:0]    out_pc_q, out_pc_d;

  // One-entry skid buffer, always younger than the output register.
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;
  logic halt_accept;
`endif

  // Combinational helpers.
  logic            consume;
  logic            out_free;
  logic [2:0]      need;
  logic [2:0]      limit;
  logic            can_issue;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] target;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Defaults: hold everything, no read, no in-flight data next cycle.
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    imem_en       = 1'b0;
`ifdef FETCH_HALT_EN
    halted_d      = halted_q;
    halt_accept   = 1'b0;
`endif

    // Branch target = branch_pc + 1 + sign_extend(offset), modulo 2^PC_W.
    // Casting the signed offset to PC_W bits sign-extends it.
    off_ext = PC_W'($signed(branch_offset));
    target  = branch_pc + PC_W'(1) + off_ext;

    consume = out_valid_q & instr_ready;
    // The output register can take a new word if it is empty or leaving now.
    out_free = ~out_valid_q | consume;

    // Issue only when the word would still have a slot on return:
    //   occ + inflight - consume < 2, rewritten without subtraction.
    need      = {2'b00, out_valid_q} + {2'b00, skid_valid_q} + {2'b00, inflight_q};
    limit     = 3'd2 + {2'b00, consume};
    can_issue = (need < limit);

    unique case (state_q)
      ST_IDLE: begin
        // One quiet cycle after reset; a redirect here seeds the first read.
        state_d = ST_RUN;
        if (branch_taken) begin
          pc_d = target;
        end
      end

      ST_RUN: begin
`ifdef FETCH_HALT_EN
        // A redirect in the same cycle takes priority over halting.
        halt_accept = consume && (out_instr_q[INSTR_W-1 -: 4] == 4'hF) && !branch_taken;
`endif
        if (branch_taken) begin
          // Flush both buffers; the in-flight read (if any) is dropped because
          // inflight_d stays 0, so its data next cycle is never captured.
          pc_d         = target;
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
        end
`ifdef FETCH_HALT_EN
        else if (halt_accept) begin
          state_d      = ST_HALT;
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
          halted_d     = 1'b1;
        end
`endif
        else begin
          // Route returning data while keeping program order:
          // the skid is older than the returning word, so it drains first.
          if (out_free) begin
            if (skid_valid_q) begin
              out_valid_d  = 1'b1;
              out_instr_d  = skid_instr_q;
              out_pc_d     = skid_pc_q;
              skid_valid_d = inflight_q;
              if (inflight_q) begin
                skid_instr_d = imem_rdata;
                skid_pc_d    = inflight_pc_q;
              end
            end else begin
              out_valid_d = inflight_q;
              if (inflight_q) begin
                out_instr_d = imem_rdata;
                out_pc_d    = inflight_pc_q;
              end
            end
          end else if (inflight_q) begin
            // Output register is stalled; the issue rule guarantees the skid
            // is empty whenever data can arrive here.
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = inflight_pc_q;
          end

          if (can_issue) begin
            imem_en       = 1'b1;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + PC_W'(1);
          end
        end
      end

      ST_HALT: begin
        // Terminal until reset: nothing issued, nothing presented, branches
        // ignored.
        out_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_addr   = pc_q;
  assign instr_valid = out_valid_q;
  assign instr       = out_instr_q;
  assign instr_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Bench for fetch_stage (PC_W=8, INSTR_W=16, OFF_W=6). A synchronous memory
// model answers reads; a transaction-level scoreboard tracks the program-order
// sequence of addresses decode should receive and checks every accepted word.
// Directed sequences check timing around reset, stalls, PC wrap, branches and
// the optional halt; a table of branch vectors checks target arithmetic; a
// randomized run exercises mixed stalls and redirects.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int OFF_W   = 6;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready = 1'b0;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               branch_taken = 1'b0;
  logic [PC_W-1:0]    branch_pc = '0;
  logic [OFF_W-1:0]   branch_offset = '0;
  logic               halted;

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .OFF_W(OFF_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .branch_taken  (branch_taken),
    .branch_pc     (branch_pc),
    .branch_offset (branch_offset),
    .halted        (halted)
  );

  // Synchronous instruction memory: one-cycle read latency, junk otherwise.
  logic [INSTR_W-1:0] mem [256];
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
    else         imem_rdata <= 16'hE0E0;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks  = 0;
  int passes  = 0;
  int accepts = 0;
  logic [PC_W-1:0]    exp_q[$];
  logic [PC_W-1:0]    exp_next = '0;
  bit                 model_halted = 1'b0;
  bit                 prev_stall = 1'b0;
  logic [INSTR_W-1:0] prev_instr = '0;
  logic [PC_W-1:0]    prev_pc = '0;

  function automatic logic [7:0] branch_target(input logic [7:0] bpc, input logic [5:0] boff);
    int off;
    off = int'(boff);
    if (off >= 32) off = off - 64;
    return 8'((int'(bpc) + 1 + off) & 255);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle. Inputs change at the falling edge, outputs are
  // observed 1 time unit later, and the scoreboard runs on that observation.
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit r, input bit rdy, input bit br,
                       input logic [7:0] bpc, input logic [5:0] boff);
    logic [PC_W-1:0] p;
    @(negedge clk);
    rst           = r;
    instr_ready   = rdy;
    branch_taken  = br;
    branch_pc     = bpc;
    branch_offset = boff;
    #1;
    if (r) begin
      exp_q.delete();
      exp_next     = '0;
      model_halted = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", 32'(instr_valid), 32'd1);
        chk("stall_instr_held", 32'(instr), 32'(prev_instr));
        chk("stall_pc_held", 32'(instr_pc), 32'(prev_pc));
      end
      if (instr_valid && rdy) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back(exp_next);
          exp_next = exp_next + 8'd1;
        end
        p = exp_q.pop_front();
        accepts++;
        chk("order_pc", 32'(instr_pc), 32'(p));
        chk("order_instr", 32'(instr), 32'(mem[p]));
`ifdef FETCH_HALT_EN
        if (instr[15:12] == 4'hF && !br) model_halted = 1'b1;
`endif
      end
      prev_stall = instr_valid && !rdy && !br && !model_halted;
      prev_instr = instr;
      prev_pc    = instr_pc;
      if (br && !model_halted) begin
        exp_q.delete();
        exp_next = branch_target(bpc, boff);
      end
    end
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, rdy, 1'b0, 8'h00, 6'h00);
  endtask

  // ---------------------------------------------------------------------------
  // Branch vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] bpc;
    logic [5:0] boff;
    logic [7:0] exp_target;
  } br_vec_t;

  br_vec_t    br_tab [6];
  logic [7:0] wrap_exp [4];
  int         rand_accepts_start;
  bit         r_rdy;
  bit         r_br;
  logic [7:0] r_bpc;
  logic [5:0] r_boff;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

    br_tab[0] = '{bpc: 8'h10, boff: 6'h3C, exp_target: 8'h0D};
    br_tab[1] = '{bpc: 8'hFF, boff: 6'h01, exp_target: 8'h01};
    br_tab[2] = '{bpc: 8'h00, boff: 6'h20, exp_target: 8'hE1};
    br_tab[3] = '{bpc: 8'h7F, boff: 6'h1F, exp_target: 8'h9F};
    br_tab[4] = '{bpc: 8'hFE, boff: 6'h3F, exp_target: 8'hFE};
    br_tab[5] = '{bpc: 8'hFF, boff: 6'h00, exp_target: 8'h00};
    wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;

    // ---- Reset state ----
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00, 6'h00);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // ---- Startup timing ----
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);                 // IDLE
    chk("start_idle_imem_en", 32'(imem_en), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);                 // first read
    chk("start_imem_en", 32'(imem_en), 32'd1);
    chk("start_imem_addr", 32'(imem_addr), 32'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);
    chk("start_valid_early", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);
      chk("start_stream_valid", 32'(instr_valid), 32'd1);
      chk("start_stream_instr", 32'(instr), 32'h1000 + 32'(i));
      chk("start_stream_pc", 32'(instr_pc), 32'(i));
    end

    // ---- Stall for 4 cycles, then release ----
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 6'h00);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      if (i >= 1) chk("stall_imem_en_off", 32'(imem_en), 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);
      chk("release_no_gap", 32'(instr_valid), 32'd1);
    end

    // ---- PC wrap: redirect to FE, stream FE FF 00 01 ----
    cycle(1'b0, 1'b1, 1'b1, 8'hFC, 6'h01);
    chk("wrap_redirect_imem_en", 32'(imem_en), 32'd0);
    run(2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);
      chk("wrap_valid", 32'(instr_valid), 32'd1);
      chk("wrap_pc", 32'(instr_pc), 32'(wrap_exp[i]));
    end

    // ---- Branch vector table ----
    for (int k = 0; k < 6; k++) begin
      run(3, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, br_tab[k].bpc, br_tab[k].boff);       // R
      chk("br_R_imem_en", 32'(imem_en), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);                         // R+1
      chk("br_R1_valid", 32'(instr_valid), 32'd0);
      chk("br_R1_imem_en", 32'(imem_en), 32'd1);
      chk("br_R1_imem_addr", 32'(imem_addr), 32'(br_tab[k].exp_target));
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);                         // R+2
      chk("br_R2_valid", 32'(instr_valid), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);                         // R+3
      chk("br_R3_valid", 32'(instr_valid), 32'd1);
      chk("br_R3_pc", 32'(instr_pc), 32'(br_tab[k].exp_target));
      chk("br_R3_instr", 32'(instr), 32'(mem[br_tab[k].exp_target]));
    end

    // ---- Halt opcode at 0x40 ----
    mem[8'h40] = 16'hF000;
    run(3, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 8'h3F, 6'h00);
    run(2, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);
    chk("halt_word_valid", 32'(instr_valid), 32'd1);
    chk("halt_word_instr", 32'(instr), 32'hF000);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);
`ifdef FETCH_HALT_EN
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_valid_off", 32'(instr_valid), 32'd0);
    chk("halt_imem_en_off", 32'(imem_en), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 8'h00, 6'h00);
    chk("halt_ignores_branch_en", 32'(imem_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);
      chk("halt_still_halted", 32'(halted), 32'd1);
      chk("halt_still_idle_en", 32'(imem_en), 32'd0);
      chk("halt_still_invalid", 32'(instr_valid), 32'd0);
    end
`else
    chk("nohalt_halted_zero", 32'(halted), 32'd0);
    chk("nohalt_next_valid", 32'(instr_valid), 32'd1);
    chk("nohalt_next_pc", 32'(instr_pc), 32'h41);
    run(4, 1'b1);
    chk("nohalt_still_fetching", 32'(instr_valid), 32'd1);
`endif
    mem[8'h40] = 16'h1040;

    // ---- Reset mid-operation ----
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 6'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 6'h00);
    chk("midrst_halted", 32'(halted), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_imem_en", 32'(imem_en), 32'd0);
    chk("midrst_instr_pc", 32'(instr_pc), 32'd0);

    // ---- Branch while IDLE seeds the first read ----
    cycle(1'b0, 1'b1, 1'b1, 8'h20, 6'h02);
    chk("idle_br_imem_en", 32'(imem_en), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);
    chk("idle_br_first_en", 32'(imem_en), 32'd1);
    chk("idle_br_first_addr", 32'(imem_addr), 32'h23);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 6'h00);
    chk("idle_br_valid", 32'(instr_valid), 32'd1);
    chk("idle_br_pc", 32'(instr_pc), 32'h23);

    // ---- Randomized stalls and redirects ----
    rand_accepts_start = accepts;
    for (int i = 0; i < 600; i++) begin
      r_rdy  = ($urandom_range(0, 3) != 0);
      r_br   = ($urandom_range(0, 24) == 0);
      r_bpc  = 8'($urandom_range(0, 255));
      r_boff = 6'($urandom_range(0, 63));
      cycle(1'b0, r_rdy, r_br, r_bpc, r_boff);
    end
    chk("random_progress", 32'((accepts - rand_accepts_start) > 200), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
